mc_fsm_controller: RTL and testbench

- Registered next-generation control FSM for the multi-cycle RV32I CPU.
- Owns the state register instead of only computing next-state from an externally held state.
- Adds variable-latency memory handshake, a multi-cycle M-extension multiply state, sticky ECALL halt, illegal-opcode recovery and a retired-instruction counter.
- Sits between the instruction register (opcode/funct7) and the datapath control decoder, which consumes `state`.

---
 rtl/mc_fsm_controller.sv | 155 +++++++++++++++
 tb/tb_mc_fsm_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_fsm_controller.sv
// Registered control FSM for the multi-cycle RV32I core. It sequences fetch, decode,
// execute, memory and writeback, and tracks halt status and the retired-instruction count.
module mc_fsm_controller #(
    parameter int MUL_EN      = 1,
    parameter int MUL_LATENCY = 4,
    parameter int MEM_WAIT_EN = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [6:0]       funct7,
    input  logic             mem_ready,
    input  logic             halt_cond,
    output logic [3:0]       state,
    output logic             mem_req,
    output logic             inst_done,
    output logic             illegal_inst,
    output logic             is_halted,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [3:0] {
        S_IF         = 4'd0,
        S_ID         = 4'd1,
        S_EX_R       = 4'd2,
        S_EX_IMM     = 4'd3,
        S_EX_LD_SD   = 4'd4,
        S_MEM_READ   = 4'd5,
        S_MEM_WRITE  = 4'd6,
        S_WB_LD      = 4'd7,
        S_WB_R_I     = 4'd8,
        S_EX_BRANCH  = 4'd9,
        S_EX_WB_JAL  = 4'd10,
        S_EX_WB_JALR = 4'd11,
        S_EX_ECALL   = 4'd12,
        S_EX_MUL     = 4'd13,
        S_HALT       = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;
    localparam logic [6:0] F7_MULDIV    = 7'b0000001;
    localparam logic [3:0] MUL_LOAD     = 4'(MUL_LATENCY - 1);

    state_t           state_q, state_d;
    logic [3:0]       mul_cnt_q;
    logic             inst_done_q, illegal_q, halted_q;
    logic [CNT_W-1:0] cnt_q;

    logic mem_ok, retire, illegal, halt_set, mul_load;

    assign mem_ok = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        illegal  = 1'b0;
        halt_set = 1'b0;
        mul_load = 1'b0;
        case (state_q)
            S_IF: if (mem_ok) state_d = S_ID;
            S_ID: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_EX_LD_SD;
                    OP_ARITH: begin
                        if ((MUL_EN != 0) && (funct7 == F7_MULDIV)) begin
                            state_d  = S_EX_MUL;
                            mul_load = 1'b1;
                        end else begin
                            state_d = S_EX_R;
                        end
                    end
                    OP_ARITH_IMM: state_d = S_EX_IMM;
                    OP_BRANCH:    state_d = S_EX_BRANCH;
                    OP_JAL:       state_d = S_EX_WB_JAL;
                    OP_JALR:      state_d = S_EX_WB_JALR;
                    OP_ECALL:     state_d = S_EX_ECALL;
                    default: begin
                        state_d = S_IF;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_EX_LD_SD: begin
                if (opcode == OP_LOAD)       state_d = S_MEM_READ;
                else if (opcode == OP_STORE) state_d = S_MEM_WRITE;
                else begin
                    state_d = S_IF;
                    illegal = 1'b1;
                end
            end
            S_MEM_READ: if (mem_ok) state_d = S_WB_LD;
            S_MEM_WRITE: begin
                if (mem_ok) begin
                    state_d = S_IF;
                    retire  = 1'b1;
                end
            end
            S_EX_R, S_EX_IMM: state_d = S_WB_R_I;
            S_EX_MUL: if (mul_cnt_q == 4'd0) state_d = S_WB_R_I;
            S_WB_LD, S_WB_R_I, S_EX_BRANCH, S_EX_WB_JAL, S_EX_WB_JALR: begin
                state_d = S_IF;
                retire  = 1'b1;
            end
            S_EX_ECALL: begin
                retire = 1'b1;
                if (halt_cond) begin
                    state_d  = S_HALT;
                    halt_set = 1'b1;
                end else begin
                    state_d = S_IF;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IF;
            mul_cnt_q   <= 4'd0;
            inst_done_q <= 1'b0;
            illegal_q   <= 1'b0;
            halted_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            inst_done_q <= retire;
            illegal_q   <= illegal;
            if (halt_set) halted_q <= 1'b1;
            if (retire)   cnt_q    <= cnt_q + 1'b1;
            // Counter holds the remaining EX_MUL cycles after the current one.
            if (mul_load)
                mul_cnt_q <= MUL_LOAD;
            else if (state_q == S_EX_MUL && mul_cnt_q != 4'd0)
                mul_cnt_q <= mul_cnt_q - 4'd1;
        end
    end

    assign state        = state_q;
    assign mem_req      = (state_q == S_IF) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    assign inst_done    = inst_done_q;
    assign illegal_inst = illegal_q;
    assign is_halted    = halted_q;
    assign retired_cnt  = cnt_q;

endmodule

// File: tb/tb_mc_fsm_controller.sv
// Directed bench: instance A uses defaults, instance B has MUL_EN=0 and a 2-bit
// retired counter; both share stimulus and are checked against hand-derived states.
module tb_mc_fsm_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode, funct7;
    logic       mem_ready, halt_cond;

    logic [3:0]  state_a, state_b;
    logic        mem_req_a, mem_req_b, done_a, done_b, ill_a, ill_b, halt_a, halt_b;
    logic [31:0] cnt_a;
    logic [1:0]  cnt_b;

    int checks = 0;
    int failures = 0;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ARITH = 7'b0110011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    always #5 clk = ~clk;

    mc_fsm_controller dut_a (
        .clk(clk), .reset(reset), .opcode(opcode), .funct7(funct7),
        .mem_ready(mem_ready), .halt_cond(halt_cond), .state(state_a),
        .mem_req(mem_req_a), .inst_done(done_a), .illegal_inst(ill_a),
        .is_halted(halt_a), .retired_cnt(cnt_a)
    );

    mc_fsm_controller #(.MUL_EN(0), .MUL_LATENCY(1), .MEM_WAIT_EN(1), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .funct7(funct7),
        .mem_ready(mem_ready), .halt_cond(halt_cond), .state(state_b),
        .mem_req(mem_req_b), .inst_done(done_b), .illegal_inst(ill_b),
        .is_halted(halt_b), .retired_cnt(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input int sa, input int sb);
        tick();
        check({tag, ".state_a"}, 32'(state_a), 32'(sa));
        check({tag, ".state_b"}, 32'(state_b), 32'(sb));
    endtask

    // Run one single-cycle-execute instruction from IF; leaves both DUTs waiting in IF.
    task automatic run_simple(input string tag, input logic [6:0] op, input int ex_state,
                              input int wb_state);
        opcode = op;
        mem_ready = 1'b1;
        step({tag, ".id"}, 1, 1);
        step({tag, ".ex"}, ex_state, ex_state);
        if (wb_state >= 0) step({tag, ".wb"}, wb_state, wb_state);
        mem_ready = 1'b0;
        step({tag, ".if"}, 0, 0);
        check({tag, ".done_a"}, 32'(done_a), 1);
        check({tag, ".done_b"}, 32'(done_b), 1);
    endtask

    initial begin
        reset = 1'b1; opcode = OP_ADDI; funct7 = 7'd0; mem_ready = 1'b1; halt_cond = 1'b0;
        tick(); tick();
        check("rst.state", 32'(state_a), 0);
        check("rst.done", 32'(done_a), 0);
        check("rst.ill", 32'(ill_a), 0);
        check("rst.halt", 32'(halt_a), 0);
        check("rst.cnt", cnt_a, 0);
        check("rst.mem_req", 32'(mem_req_a), 1);
        reset = 1'b0;

        // ADDI: 0,1,3,8,0 with inst_done in the 5th cycle
        step("addi.id", 1, 1);
        check("addi.done_early", 32'(done_a), 0);
        step("addi.ex", 3, 3);
        step("addi.wb", 8, 8);
        mem_ready = 1'b0;
        step("addi.if", 0, 0);
        check("addi.done", 32'(done_a), 1);
        check("addi.cnt", cnt_a, 1);
        step("addi.hold", 0, 0);
        check("addi.done_clr", 32'(done_a), 0);

        // LW: IF held four cycles in total, MEM_READ held three
        opcode = OP_LOAD;
        for (int i = 0; i < 2; i++) begin
            step("lw.if_wait", 0, 0);
            check("lw.if_req", 32'(mem_req_a), 1);
        end
        mem_ready = 1'b1;
        step("lw.id", 1, 1);
        check("lw.id_req", 32'(mem_req_a), 0);
        step("lw.ex", 4, 4);
        check("lw.ex_req", 32'(mem_req_a), 0);
        step("lw.mem", 5, 5);
        check("lw.mem_req", 32'(mem_req_a), 1);
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step("lw.mem_wait", 5, 5);
            check("lw.mem_wait_req", 32'(mem_req_a), 1);
        end
        mem_ready = 1'b1;
        step("lw.wb", 7, 7);
        check("lw.wb_req", 32'(mem_req_a), 0);
        mem_ready = 1'b0;
        step("lw.if", 0, 0);
        check("lw.done", 32'(done_a), 1);
        check("lw.cnt", cnt_a, 2);

        // MUL: A spends 4 cycles in EX_MUL, B takes the plain EX_R path
        opcode = OP_ARITH; funct7 = 7'b0000001; mem_ready = 1'b1;
        step("mul.id", 1, 1);
        step("mul.ex1", 13, 2);
        step("mul.ex2", 13, 8);
        mem_ready = 1'b0;
        step("mul.ex3", 13, 0);
        check("mul.done_b", 32'(done_b), 1);
        check("mul.cnt_b", 32'(cnt_b), 3);
        step("mul.ex4", 13, 0);
        step("mul.wb", 8, 0);
        step("mul.if", 0, 0);
        check("mul.done_a", 32'(done_a), 1);
        check("mul.cnt_a", cnt_a, 3);

        // Undecodable opcode: back to IF, one-cycle illegal pulse, no retirement
        opcode = 7'b1111111; funct7 = 7'd0; mem_ready = 1'b1;
        step("ill.id", 1, 1);
        mem_ready = 1'b0;
        step("ill.if", 0, 0);
        check("ill.pulse", 32'(ill_a), 1);
        check("ill.pulse_b", 32'(ill_b), 1);
        check("ill.done", 32'(done_a), 0);
        check("ill.cnt", cnt_a, 3);
        step("ill.hold", 0, 0);
        check("ill.clr", 32'(ill_a), 0);

        // Reset in EX_MUL cycle 2
        opcode = OP_ARITH; funct7 = 7'b0000001; mem_ready = 1'b1;
        step("rmul.id", 1, 1);
        step("rmul.ex1", 13, 2);
        step("rmul.ex2", 13, 8);
        reset = 1'b1; mem_ready = 1'b0;
        step("rmul.rst", 0, 0);
        check("rmul.cnt_a", cnt_a, 0);
        check("rmul.cnt_b", 32'(cnt_b), 0);
        check("rmul.done_b", 32'(done_b), 0);
        reset = 1'b0;

        // Reset in a MEM_READ wait
        opcode = OP_LOAD; funct7 = 7'd0; mem_ready = 1'b1;
        step("rmem.id", 1, 1);
        step("rmem.ex", 4, 4);
        step("rmem.mem", 5, 5);
        mem_ready = 1'b0;
        step("rmem.wait", 5, 5);
        reset = 1'b1;
        step("rmem.rst", 0, 0);
        reset = 1'b0;

        // SW completes normally after a write wait
        opcode = OP_STORE; mem_ready = 1'b1;
        step("sw.id", 1, 1);
        step("sw.ex", 4, 4);
        step("sw.mem", 6, 6);
        check("sw.mem_req", 32'(mem_req_a), 1);
        mem_ready = 1'b0;
        step("sw.wait", 6, 6);
        mem_ready = 1'b1;
        step("sw.if", 0, 0);
        check("sw.done", 32'(done_a), 1);
        check("sw.cnt", cnt_a, 1);
        mem_ready = 1'b0;
        step("sw.hold", 0, 0);

        // Three more retirements: B's 2-bit counter wraps to 0
        for (int i = 0; i < 3; i++) run_simple("wrap", OP_ADDI, 3, 8);
        check("wrap.cnt_a", cnt_a, 4);
        check("wrap.cnt_b", 32'(cnt_b), 0);

        run_simple("br", OP_BR, 9, -1);
        run_simple("jal", OP_JAL, 10, -1);
        run_simple("jalr", OP_JALR, 11, -1);
        check("jmp.cnt_a", cnt_a, 7);
        check("jmp.cnt_b", 32'(cnt_b), 3);

        // ECALL without halt retires and returns to IF
        halt_cond = 1'b0;
        run_simple("ecall0", OP_ECALL, 12, -1);
        check("ecall0.halt", 32'(halt_a), 0);
        check("ecall0.cnt", cnt_a, 8);

        // ECALL with halt: absorbing HALT
        opcode = OP_ECALL; halt_cond = 1'b1; mem_ready = 1'b1;
        step("halt.id", 1, 1);
        step("halt.ex", 12, 12);
        step("halt.enter", 14, 14);
        check("halt.flag", 32'(halt_a), 1);
        check("halt.done", 32'(done_a), 1);
        check("halt.cnt", cnt_a, 9);
        halt_cond = 1'b0;
        for (int i = 0; i < 20; i++) begin
            opcode = (i % 2 == 0) ? OP_ADDI : OP_LOAD;
            step("halt.hold", 14, 14);
            check("halt.mem_req", 32'(mem_req_a), 0);
            check("halt.sticky", 32'(halt_a), 1);
            check("halt.no_done", 32'(done_a), 0);
        end
        check("halt.cnt_hold", cnt_a, 9);
        reset = 1'b1;
        step("halt.rst", 0, 0);
        check("halt.rst_flag", 32'(halt_a), 0);
        check("halt.rst_cnt", cnt_a, 0);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
